scratchpad_read_port: RTL and testbench

// - Read side of the scratchpad register file: the two operand buses (A, B) handed to the ALU.
// - Takes a read request (two register selects) with valid/ready and samples the flattened register file.
// - Returns registered A/B data with valid/ready. Outputs hold stable under backpressure.
// - Detects read-after-write hazards against the decoder's active-low write strobes in the same cycle.

---
 rtl/scratchpad_read_port.sv | 166 ++++++++++++++++
 tb/tb_scratchpad_read_port.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scratchpad_read_port.sv
// Purpose: read side of the scratchpad register file; returns operands A/B for the ALU.
// Latency: 1 cycle from accept to response, or 2 when a same-cycle write hazard forces a stall.
// Backpressure: the response holds stable while Rsp_Ready is low, and no new request is accepted then.
//
// Ports:
//   SC_ReadPort_CLOCK_50 / SC_ReadPort_RESET_InLow : clock, async active-low reset
//   SC_ReadPort_Req_Valid/_Ready, SelA, SelB        : read request (two register selects)
//   SC_ReadPort_RegFile_DataBUS_In                  : flat register file, reg i at [i*W +: W]
//   SC_ReadPort_Write_InLow, SC_ReadPort_WriteData_In : decoder write strobes (0 = written) and write data
//   SC_ReadPort_DataBUS_A_Out/_B_Out, Error_Out     : registered response, Error_Out = a select was out of range
//   SC_ReadPort_Rsp_Valid/_Ready                    : response handshake
//
// Build option: define SCRATCHPAD_READ_BYPASS_EN to forward WriteData_In to a hazarded port
// instead of stalling one cycle.
module scratchpad_read_port #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int NUM_REGS      = 13,
  parameter int DATAWIDTH_SEL = 5
) (
  input  logic                              SC_ReadPort_CLOCK_50,
  input  logic                              SC_ReadPort_RESET_InLow,
  input  logic                              SC_ReadPort_Req_Valid,
  output logic                              SC_ReadPort_Req_Ready,
  input  logic [DATAWIDTH_SEL-1:0]          SC_ReadPort_SelA,
  input  logic [DATAWIDTH_SEL-1:0]          SC_ReadPort_SelB,
  input  logic [NUM_REGS*DATAWIDTH_BUS-1:0] SC_ReadPort_RegFile_DataBUS_In,
  input  logic [NUM_REGS-1:0]               SC_ReadPort_Write_InLow,
  input  logic [DATAWIDTH_BUS-1:0]          SC_ReadPort_WriteData_In,
  output logic [DATAWIDTH_BUS-1:0]          SC_ReadPort_DataBUS_A_Out,
  output logic [DATAWIDTH_BUS-1:0]          SC_ReadPort_DataBUS_B_Out,
  output logic                              SC_ReadPort_Rsp_Valid,
  input  logic                              SC_ReadPort_Rsp_Ready,
  output logic                              SC_ReadPort_Error_Out
);

  typedef enum logic [1:0] {IDLE, STALL, HOLD} state_t;

  state_t                   state_q, state_d;
  logic                     init_q;      // low only until the first edge after reset release
  logic [DATAWIDTH_SEL-1:0] sel_a_q, sel_b_q;
  logic [DATAWIDTH_BUS-1:0] a_q, b_q;
  logic                     err_q;

  logic                     req_rdy, accept, load, load_from_q, capture;
  logic                     haz_a, haz_b, stall_needed, byp_a, byp_b;
  logic [DATAWIDTH_SEL-1:0] rd_sel_a, rd_sel_b;
  logic [DATAWIDTH_BUS-1:0] a_nxt, b_nxt;
  logic                     err_nxt;

  function automatic logic in_range(input logic [DATAWIDTH_SEL-1:0] s);
    return int'(s) < NUM_REGS;
  endfunction

  // Out-of-range selects match no register and fall through to zero.
  function automatic logic [DATAWIDTH_BUS-1:0] read_reg(
    input logic [DATAWIDTH_SEL-1:0]          s,
    input logic [NUM_REGS*DATAWIDTH_BUS-1:0] bus
  );
    logic [DATAWIDTH_BUS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (int'(s) == i) r = bus[i*DATAWIDTH_BUS +: DATAWIDTH_BUS];
    return r;
  endfunction

  // Register 0 is fixed, so its strobe never creates a hazard; the loop starts at 1.
  function automatic logic hazard(
    input logic [DATAWIDTH_SEL-1:0] s,
    input logic [NUM_REGS-1:0]      wr_n
  );
    logic h;
    h = 1'b0;
    for (int i = 1; i < NUM_REGS; i++)
      if (int'(s) == i && !wr_n[i]) h = 1'b1;
    return h;
  endfunction

  assign haz_a = hazard(SC_ReadPort_SelA, SC_ReadPort_Write_InLow);
  assign haz_b = hazard(SC_ReadPort_SelB, SC_ReadPort_Write_InLow);

`ifdef SCRATCHPAD_READ_BYPASS_EN
  assign byp_a        = haz_a;
  assign byp_b        = haz_b;
  assign stall_needed = 1'b0;
`else
  logic unused_wdata;
  assign byp_a        = 1'b0;
  assign byp_b        = 1'b0;
  assign stall_needed = haz_a | haz_b;
  assign unused_wdata = ^SC_ReadPort_WriteData_In;
`endif

  logic unused_strobe0;
  assign unused_strobe0 = SC_ReadPort_Write_InLow[0];

  always_comb begin
    state_d     = state_q;
    req_rdy     = 1'b0;
    load        = 1'b0;
    load_from_q = 1'b0;
    capture     = 1'b0;
    case (state_q)
      IDLE:    req_rdy = init_q;
      STALL:   req_rdy = 1'b0;
      HOLD:    req_rdy = SC_ReadPort_Rsp_Ready;
      default: req_rdy = 1'b0;
    endcase
    accept = SC_ReadPort_Req_Valid & req_rdy;

    if (state_q == STALL) begin
      // The write landed on the previous edge, so the flat bus now holds the new value.
      load        = 1'b1;
      load_from_q = 1'b1;
      state_d     = HOLD;
    end else if (accept) begin
      if (stall_needed) begin
        capture = 1'b1;
        state_d = STALL;
      end else begin
        load    = 1'b1;
        state_d = HOLD;
      end
    end else if (state_q == HOLD && SC_ReadPort_Rsp_Ready) begin
      state_d = IDLE;
    end
  end

  assign rd_sel_a = load_from_q ? sel_a_q : SC_ReadPort_SelA;
  assign rd_sel_b = load_from_q ? sel_b_q : SC_ReadPort_SelB;
  assign a_nxt    = byp_a ? SC_ReadPort_WriteData_In
                          : read_reg(rd_sel_a, SC_ReadPort_RegFile_DataBUS_In);
  assign b_nxt    = byp_b ? SC_ReadPort_WriteData_In
                          : read_reg(rd_sel_b, SC_ReadPort_RegFile_DataBUS_In);
  assign err_nxt  = !in_range(rd_sel_a) || !in_range(rd_sel_b);

  always_ff @(posedge SC_ReadPort_CLOCK_50 or negedge SC_ReadPort_RESET_InLow) begin
    if (!SC_ReadPort_RESET_InLow) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
      sel_a_q <= '0;
      sel_b_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      if (capture) begin
        sel_a_q <= SC_ReadPort_SelA;
        sel_b_q <= SC_ReadPort_SelB;
      end
      if (load) begin
        a_q   <= a_nxt;
        b_q   <= b_nxt;
        err_q <= err_nxt;
      end
    end
  end

  assign SC_ReadPort_Req_Ready     = req_rdy;
  assign SC_ReadPort_Rsp_Valid     = (state_q == HOLD);
  assign SC_ReadPort_DataBUS_A_Out = a_q;
  assign SC_ReadPort_DataBUS_B_Out = b_q;
  assign SC_ReadPort_Error_Out     = err_q;

endmodule

// File: tb/tb_scratchpad_read_port.sv
// Purpose: self-checking bench for scratchpad_read_port (directed scenarios plus random traffic).
// Latency: the bench acts as the register file and predicts responses at transaction level.
// Backpressure: Rsp_Ready is toggled randomly; held responses are compared every cycle.
module tb_scratchpad_read_port;

  localparam int W = 32;
  localparam int N = 13;
  localparam int S = 5;
`ifdef SCRATCHPAD_READ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_vld, req_rdy, rsp_vld, rsp_rdy, err;
  logic [S-1:0]   sel_a, sel_b;
  logic [N-1:0]   wr_n;
  logic [W-1:0]   wdata, a_out, b_out;
  logic [W-1:0]   regs [N];
  logic [N*W-1:0] flat;

  int n_cmp  = 0;
  int n_fail = 0;

  // Transaction-level prediction of the response stream.
  logic         exp_vld, pend, init_ok, exp_err, pend_err;
  logic [W-1:0] exp_a, exp_b, pend_a, pend_b;

  always #5 clk = ~clk;

  always_comb begin
    flat = '0;
    for (int i = 0; i < N; i++) flat[i*W +: W] = regs[i];
  end

  scratchpad_read_port #(.DATAWIDTH_BUS(W), .NUM_REGS(N), .DATAWIDTH_SEL(S)) dut (
    .SC_ReadPort_CLOCK_50          (clk),
    .SC_ReadPort_RESET_InLow       (rst_n),
    .SC_ReadPort_Req_Valid         (req_vld),
    .SC_ReadPort_Req_Ready         (req_rdy),
    .SC_ReadPort_SelA              (sel_a),
    .SC_ReadPort_SelB              (sel_b),
    .SC_ReadPort_RegFile_DataBUS_In(flat),
    .SC_ReadPort_Write_InLow       (wr_n),
    .SC_ReadPort_WriteData_In      (wdata),
    .SC_ReadPort_DataBUS_A_Out     (a_out),
    .SC_ReadPort_DataBUS_B_Out     (b_out),
    .SC_ReadPort_Rsp_Valid         (rsp_vld),
    .SC_ReadPort_Rsp_Ready         (rsp_rdy),
    .SC_ReadPort_Error_Out         (err)
  );

  function automatic logic model_rdy();
    if (pend) return 1'b0;
    if (exp_vld) return rsp_rdy;
    return init_ok;
  endfunction

  function automatic logic is_haz(input logic [S-1:0] s, input logic [N-1:0] w);
    return (s >= 1) && (s < N) && !w[s];
  endfunction

  task automatic model_reset();
    exp_vld = 1'b0; pend = 1'b0; init_ok = 1'b0;
    exp_a = '0; exp_b = '0; exp_err = 1'b0;
  endtask

  // Advances one clock: applies register writes and the expected handshake outcome.
  task automatic step(output logic acc_o);
    logic         acc, cons, ha, hb, e;
    logic [W-1:0] nx [N];
    logic [W-1:0] va, vb;
    #2;
    acc  = req_vld && model_rdy();
    cons = exp_vld && rsp_rdy;
    for (int i = 0; i < N; i++) nx[i] = regs[i];
    for (int i = 1; i < N; i++) if (!wr_n[i]) nx[i] = wdata;
    ha = is_haz(sel_a, wr_n);
    hb = is_haz(sel_b, wr_n);
    // Either path (stall or bypass) yields the post-write register value.
    va = (sel_a < N) ? nx[sel_a] : '0;
    vb = (sel_b < N) ? nx[sel_b] : '0;
    e  = (sel_a >= N) || (sel_b >= N);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) regs[i] = nx[i];
    if (rst_n) init_ok = 1'b1;
    if (pend) begin
      exp_vld = 1'b1; exp_a = pend_a; exp_b = pend_b; exp_err = pend_err; pend = 1'b0;
    end else if (acc) begin
      if ((ha || hb) && !BYPASS) begin
        pend = 1'b1; pend_a = va; pend_b = vb; pend_err = e; exp_vld = 1'b0;
      end else begin
        exp_vld = 1'b1; exp_a = va; exp_b = vb; exp_err = e;
      end
    end else if (cons) begin
      exp_vld = 1'b0;
    end
    acc_o = acc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_vld = 1'b1; sel_a = 5'd1; sel_b = 5'd2;
    wr_n = '1; wdata = '0; rsp_rdy = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (a_out !== 32'h0)   begin n_fail++; $display("FAIL reset_a got=%h exp=0", a_out); end
    n_cmp++; if (b_out !== 32'h0)   begin n_fail++; $display("FAIL reset_b got=%h exp=0", b_out); end
    n_cmp++; if (rsp_vld !== 1'b0)  begin n_fail++; $display("FAIL reset_rsp_vld got=%b exp=0", rsp_vld); end
    n_cmp++; if (err !== 1'b0)      begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    n_cmp++; if (req_rdy !== 1'b0)  begin n_fail++; $display("FAIL reset_req_rdy got=%b exp=0", req_rdy); end
    rst_n = 1'b1; req_vld = 1'b0;
    #1;
    n_cmp++; if (req_rdy !== 1'b0)  begin n_fail++; $display("FAIL release_rdy_early got=%b exp=0", req_rdy); end
  endtask

  task automatic test_basic_read();
    logic d;
    n_cmp++; if (req_rdy !== 1'b1)  begin n_fail++; $display("FAIL release_rdy got=%b exp=1", req_rdy); end
    req_vld = 1'b1; sel_a = 5'd1; sel_b = 5'd2; rsp_rdy = 1'b0;
    step(d);
    req_vld = 1'b0;
    n_cmp++; if (rsp_vld !== 1'b1)      begin n_fail++; $display("FAIL basic_vld got=%b exp=1", rsp_vld); end
    n_cmp++; if (a_out !== 32'h11)      begin n_fail++; $display("FAIL basic_a got=%h exp=11", a_out); end
    n_cmp++; if (b_out !== 32'h22)      begin n_fail++; $display("FAIL basic_b got=%h exp=22", b_out); end
    n_cmp++; if (err !== 1'b0)          begin n_fail++; $display("FAIL basic_err got=%b exp=0", err); end
  endtask

  task automatic test_backpressure();
    logic d;
    for (int c = 0; c < 3; c++) begin
      rsp_rdy = 1'b0;
      wr_n = '1; if (c == 0) begin wr_n[1] = 1'b0; wdata = 32'hFFFF0000; end
      #1;
      n_cmp++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_req_rdy c=%0d got=%b exp=0", c, req_rdy); end
      step(d);
      n_cmp++; if (a_out !== 32'h11) begin n_fail++; $display("FAIL bp_hold_a c=%0d got=%h exp=11", c, a_out); end
      n_cmp++; if (rsp_vld !== 1'b1) begin n_fail++; $display("FAIL bp_hold_vld c=%0d got=%b exp=1", c, rsp_vld); end
    end
    wr_n = '1; rsp_rdy = 1'b1; req_vld = 1'b1; sel_a = 5'd8; sel_b = 5'd2;
    #1;
    n_cmp++; if (req_rdy !== 1'b1)     begin n_fail++; $display("FAIL b2b_req_rdy got=%b exp=1", req_rdy); end
    step(d);
    req_vld = 1'b0;
    n_cmp++; if (rsp_vld !== 1'b1)     begin n_fail++; $display("FAIL b2b_vld got=%b exp=1", rsp_vld); end
    n_cmp++; if (a_out !== 32'h40)     begin n_fail++; $display("FAIL b2b_a got=%h exp=40", a_out); end
    n_cmp++; if (b_out !== 32'h22)     begin n_fail++; $display("FAIL b2b_b got=%h exp=22", b_out); end
    step(d);
    n_cmp++; if (rsp_vld !== 1'b0)     begin n_fail++; $display("FAIL drain_vld got=%b exp=0", rsp_vld); end
  endtask

  task automatic test_hazard();
    logic d;
    req_vld = 1'b1; sel_a = 5'd3; sel_b = 5'd1; rsp_rdy = 1'b1;
    wr_n = '1; wr_n[3] = 1'b0; wdata = 32'h0000CAFE;
    step(d);
    req_vld = 1'b0; wr_n = '1;
`ifndef SCRATCHPAD_READ_BYPASS_EN
    n_cmp++; if (rsp_vld !== 1'b0)     begin n_fail++; $display("FAIL haz_stall_vld got=%b exp=0", rsp_vld); end
    n_cmp++; if (req_rdy !== 1'b0)     begin n_fail++; $display("FAIL haz_stall_rdy got=%b exp=0", req_rdy); end
    step(d);
`endif
    n_cmp++; if (rsp_vld !== 1'b1)         begin n_fail++; $display("FAIL haz_vld got=%b exp=1", rsp_vld); end
    n_cmp++; if (a_out !== 32'h0000CAFE)   begin n_fail++; $display("FAIL haz_a got=%h exp=0000cafe", a_out); end
    n_cmp++; if (b_out !== 32'hFFFF0000)   begin n_fail++; $display("FAIL haz_b got=%h exp=ffff0000", b_out); end
    step(d);
  endtask

  task automatic test_out_of_range();
    logic d;
    req_vld = 1'b1; sel_a = 5'd0; sel_b = 5'd13; rsp_rdy = 1'b0; wr_n = '1;
    step(d);
    n_cmp++; if (a_out !== 32'h09)     begin n_fail++; $display("FAIL oor_a got=%h exp=09", a_out); end
    n_cmp++; if (b_out !== 32'h0)      begin n_fail++; $display("FAIL oor_b got=%h exp=0", b_out); end
    n_cmp++; if (err !== 1'b1)         begin n_fail++; $display("FAIL oor_err got=%b exp=1", err); end
    rsp_rdy = 1'b1; sel_a = 5'd2; sel_b = 5'd2;
    step(d);
    req_vld = 1'b0;
    n_cmp++; if (err !== 1'b0)         begin n_fail++; $display("FAIL oor_clear_err got=%b exp=0", err); end
    n_cmp++; if (a_out !== 32'h22 || b_out !== 32'h22)
      begin n_fail++; $display("FAIL same_sel got=%h/%h exp=22/22", a_out, b_out); end
    step(d);
  endtask

  task automatic test_async_reset();
    logic d;
    req_vld = 1'b1; sel_a = 5'd1; sel_b = 5'd2; rsp_rdy = 1'b0; wr_n = '1;
    step(d);
    req_vld = 1'b0;
    n_cmp++; if (rsp_vld !== 1'b1)     begin n_fail++; $display("FAIL ar_pre_vld got=%b exp=1", rsp_vld); end
    #2; rst_n = 1'b0; #1;
    n_cmp++; if (rsp_vld !== 1'b0)     begin n_fail++; $display("FAIL ar_vld got=%b exp=0", rsp_vld); end
    n_cmp++; if (a_out !== 32'h0 || b_out !== 32'h0)
      begin n_fail++; $display("FAIL ar_data got=%h/%h exp=0/0", a_out, b_out); end
    n_cmp++; if (req_rdy !== 1'b0)     begin n_fail++; $display("FAIL ar_rdy got=%b exp=0", req_rdy); end
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_rdy = 1'b1;
    model_reset();
    step(d);
    n_cmp++; if (rsp_vld !== 1'b0 || req_rdy !== 1'b1)
      begin n_fail++; $display("FAIL ar_idle got vld=%b rdy=%b exp vld=0 rdy=1", rsp_vld, req_rdy); end
  endtask

  task automatic test_random();
    logic acc = 1'b1;
    for (int i = 1; i < N; i++) regs[i] = $urandom;
    for (int k = 0; k < 500; k++) begin
      if (acc || !req_vld) begin
        req_vld = ($urandom_range(0, 3) != 0);
        sel_a   = 5'($urandom_range(0, 15));
        sel_b   = ($urandom_range(0, 7) == 0) ? sel_a : 5'($urandom_range(0, 15));
      end
      for (int i = 0; i < N; i++) wr_n[i] = ($urandom_range(0, 3) != 0);
      wdata   = $urandom;
      rsp_rdy = ($urandom_range(0, 2) != 0);
      #1;
      n_cmp++; if (req_rdy !== model_rdy())
        begin n_fail++; $display("FAIL rnd_req_rdy k=%0d got=%b exp=%b", k, req_rdy, model_rdy()); end
      step(acc);
      n_cmp++; if (rsp_vld !== exp_vld)
        begin n_fail++; $display("FAIL rnd_vld k=%0d got=%b exp=%b", k, rsp_vld, exp_vld); end
      if (exp_vld) begin
        n_cmp++; if (a_out !== exp_a || b_out !== exp_b || err !== exp_err)
          begin n_fail++; $display("FAIL rnd_data k=%0d got=%h/%h/%b exp=%h/%h/%b",
                                   k, a_out, b_out, err, exp_a, exp_b, exp_err); end
      end
    end
    req_vld = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) regs[i] = '0;
    regs[0] = 32'h09; regs[1] = 32'h11; regs[2] = 32'h22; regs[3] = 32'h5; regs[8] = 32'h40;
    test_reset();
    @(posedge clk); #1;
    test_basic_read();
    test_backpressure();
    test_hazard();
    test_out_of_range();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
